// File: rtl/otter_io_timer.sv
// ============================================================================
// otter_io_timer
// ----------------------------------------------------------------------------
// Memory-mapped countdown timer on the OTTER IOBUS. The MCU writes and reads
// four 32-bit registers in a 16-byte window at BASE_ADDR; the timer raises a
// level interrupt (INTR) when its count expires with interrupts enabled.
//
// Register map (offset = IOBUS_ADDR[3:2], IOBUS_ADDR[1:0] ignored):
//   0x0 CTRL   R/W  bit0 EN, bit1 AR (auto-reload), bit2 IE,
//                   [15:8] PRESCALE (only with OTTER_TIMER_PRESCALE_EN)
//   0x4 LOAD   R/W  reload value; a write also loads COUNT
//   0x8 COUNT  RO   current count, writes ignored
//   0xC STATUS      bit0 EXP, sticky; write 1 to clear
//
// Bus protocol: there is no valid/ready handshake and no wait state. A write
// is accepted on every rising CLK edge where IOBUS_WR=1 and the address is in
// the window; read data on IOBUS_IN is combinational from IOBUS_ADDR and the
// registers in the same cycle. Unselected addresses read 0.
//
// Configuration macro:
//   OTTER_TIMER_PRESCALE_EN  defined   -> 8-bit prescaler, tick when PS==PRESCALE
//                            undefined -> tick every cycle while EN=1,
//                                         CTRL[15:8] reads 0, writes ignored
//
// Ports:
//   CLK         system clock (shared with the MCU)
//   RST_N       asynchronous active-low reset
//   IOBUS_ADDR  byte address from the MCU
//   IOBUS_OUT   write data from the MCU
//   IOBUS_WR    write strobe
//   IOBUS_IN    read data to the MCU
//   INTR        level interrupt request, EXP & IE
// ============================================================================
module otter_io_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] offset;
    logic       wr_ctrl;
    logic       wr_load;
    logic       wr_status;
    logic       unused_addr_bits;

    assign sel       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign offset    = IOBUS_ADDR[3:2];
    assign wr_ctrl   = IOBUS_WR && sel && (offset == OFF_CTRL);
    assign wr_load   = IOBUS_WR && sel && (offset == OFF_LOAD);
    assign wr_status = IOBUS_WR && sel && (offset == OFF_STATUS);

    // Byte-lane bits carry no meaning for this word-only peripheral.
    assign unused_addr_bits = ^IOBUS_ADDR[1:0];

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic        en_q;
    logic        ar_q;
    logic        ie_q;
    logic [31:0] load_q;
    logic [31:0] count_q;
    logic        exp_q;
    logic [7:0]  prescale_rd;

    logic        tick;
    logic        count_zero;
    logic        expire;

    assign count_zero = (count_q == 32'd0);

    // A LOAD write on a tick edge takes priority: the tick is consumed by the
    // write, so no decrement and no expiry happen on that edge.
    assign expire = tick && count_zero && !wr_load;

`ifdef OTTER_TIMER_PRESCALE_EN
    // ------------------------------------------------------------------
    // Prescaler: PS counts 0..PRESCALE while enabled, ticking on the match.
    // Holding PS at 0 while disabled means an EN 0->1 write always starts a
    // fresh prescale period, so the first tick is PRESCALE+1 cycles later.
    // ------------------------------------------------------------------
    logic [7:0] prescale_q;
    logic [7:0] ps_q;

    assign tick        = en_q && (ps_q == prescale_q);
    assign prescale_rd = prescale_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps_q       <= 8'd0;
            prescale_q <= 8'd0;
        end else begin
            if (!en_q || tick) begin
                ps_q <= 8'd0;
            end else begin
                ps_q <= ps_q + 8'd1;
            end
            if (wr_ctrl) begin
                prescale_q <= IOBUS_OUT[15:8];
            end
        end
    end
`else
    // No prescaler: every enabled cycle is a tick.
    assign tick        = en_q;
    assign prescale_rd = 8'd0;
`endif

    // ------------------------------------------------------------------
    // CTRL, LOAD/COUNT and STATUS
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            exp_q   <= 1'b0;
        end else begin
            // Software CTRL write overrides the one-shot hardware EN clear.
            if (wr_ctrl) begin
                en_q <= IOBUS_OUT[0];
                ar_q <= IOBUS_OUT[1];
                ie_q <= IOBUS_OUT[2];
            end else if (expire && !ar_q) begin
                en_q <= 1'b0;
            end

            if (wr_load) begin
                load_q  <= IOBUS_OUT;
                count_q <= IOBUS_OUT;
            end else if (tick) begin
                if (!count_zero) begin
                    count_q <= count_q - 32'd1;
                end else if (ar_q) begin
                    count_q <= load_q;
                end
                // One-shot expiry leaves COUNT parked at zero.
            end

            // Expiry beats a simultaneous write-1-clear so no event is lost.
            if (expire) begin
                exp_q <= 1'b1;
            end else if (wr_status && IOBUS_OUT[0]) begin
                exp_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        IOBUS_IN = 32'd0;
        if (sel) begin
            case (offset)
                OFF_CTRL:   IOBUS_IN = {16'd0, prescale_rd, 5'd0, ie_q, ar_q, en_q};
                OFF_LOAD:   IOBUS_IN = load_q;
                OFF_COUNT:  IOBUS_IN = count_q;
                OFF_STATUS: IOBUS_IN = {31'd0, exp_q};
                default:    IOBUS_IN = 32'd0;
            endcase
        end
    end

    assign INTR = exp_q && ie_q;

endmodule

// File: tb/tb_otter_io_timer.sv
module tb_otter_io_timer;

  localparam logic [31:0] B = 32'h1100_0100;

`ifdef OTTER_TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_FF_RD  = 32'h0000_FF00;
  localparam logic [31:0] CTRL_103_RD = 32'h0000_0103;
`else
  localparam logic [31:0] CTRL_FF_RD  = 32'h0000_0000;
  localparam logic [31:0] CTRL_103_RD = 32'h0000_0003;
`endif

  logic        CLK;
  logic        RST_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  int checks = 0;
  int passed = 0;

  otter_io_timer #(.BASE_ADDR(B)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INTR       (INTR)
  );

  // clock / watchdog
  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // driver tasks; every task starts and ends between a negedge and the next posedge
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = addr;
    #1;
    check(name, IOBUS_IN, exp);
  endtask

  task automatic chk_intr(input string name, input logic exp);
    check(name, {31'd0, INTR}, {31'd0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // vector table: one bus cycle each; rd is observed before the edge commits the write
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_intr;
    string       name;
  } vec_t;

  vec_t vecs[$];

  int exp_cnt[13];
  int exp_st[13];

  initial begin
    RST_N      = 1'b0;
    IOBUS_ADDR = B;
    IOBUS_OUT  = 32'd0;
    IOBUS_WR   = 1'b0;

    vecs.push_back('{1'b0, B + 32'h0,  32'h0,        32'h0,      1'b0, "v00 ctrl after reset"});
    vecs.push_back('{1'b1, B + 32'h4,  32'h3,        32'h0,      1'b0, "v01 wr load 3"});
    vecs.push_back('{1'b1, B + 32'h0,  32'h5,        32'h0,      1'b0, "v02 wr ctrl 5"});
    vecs.push_back('{1'b0, B + 32'h8,  32'h0,        32'h3,      1'b0, "v03 count 3"});
    vecs.push_back('{1'b0, B + 32'h8,  32'h0,        32'h2,      1'b0, "v04 count 2"});
    vecs.push_back('{1'b0, B + 32'h8,  32'h0,        32'h1,      1'b0, "v05 count 1"});
    vecs.push_back('{1'b0, B + 32'h8,  32'h0,        32'h0,      1'b0, "v06 count 0"});
    vecs.push_back('{1'b0, B + 32'hC,  32'h0,        32'h1,      1'b1, "v07 exp set"});
    vecs.push_back('{1'b0, B + 32'h0,  32'h0,        32'h4,      1'b1, "v08 ctrl en cleared"});
    vecs.push_back('{1'b1, B + 32'hC,  32'h0,        32'h1,      1'b1, "v09 status wr0"});
    vecs.push_back('{1'b1, B + 32'hC,  32'h1,        32'h1,      1'b1, "v10 status wr1"});
    vecs.push_back('{1'b0, B + 32'hC,  32'h0,        32'h0,      1'b0, "v11 exp cleared"});
    vecs.push_back('{1'b1, B + 32'h4,  32'h7,        32'h3,      1'b0, "v12 wr load 7"});
    vecs.push_back('{1'b1, B + 32'h10, 32'hFFFF_FFFF, 32'h0,     1'b0, "v13 wr outside"});
    vecs.push_back('{1'b0, B + 32'h4,  32'h0,        32'h7,      1'b0, "v14 load 7"});
    vecs.push_back('{1'b0, B + 32'hB,  32'h0,        32'h7,      1'b0, "v15 count lanes 11"});
    vecs.push_back('{1'b0, B + 32'h0,  32'h0,        32'h4,      1'b0, "v16 ctrl untouched"});
    vecs.push_back('{1'b1, B + 32'h8,  32'h55,       32'h7,      1'b0, "v17 wr count"});
    vecs.push_back('{1'b0, B + 32'h8,  32'h0,        32'h7,      1'b0, "v18 count ro"});
    vecs.push_back('{1'b1, B + 32'h0,  32'h0000_FFF0, 32'h4,     1'b0, "v19 wr ctrl fff0"});
    vecs.push_back('{1'b0, B + 32'h0,  32'h0,        CTRL_FF_RD, 1'b0, "v20 ctrl masked"});
    vecs.push_back('{1'b0, B + 32'h8,  32'h0,        32'h7,      1'b0, "v21 count idle"});
    vecs.push_back('{1'b1, B + 32'h0,  32'h0,        CTRL_FF_RD, 1'b0, "v22 wr ctrl 0"});
    vecs.push_back('{1'b0, B + 32'h0,  32'h0,        32'h0,      1'b0, "v23 ctrl 0"});

`ifdef OTTER_TIMER_PRESCALE_EN
    exp_cnt = '{2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2};
    exp_st  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
`else
    exp_cnt = '{2, 1, 0, 2, 1, 0, 2, 1, 0, 2, 1, 0, 2};
    exp_st  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

    // reset block
    #25;
    rd("reset ctrl", B + 32'h0, 32'h0);
    chk_intr("reset intr", 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      IOBUS_ADDR = vecs[i].addr;
      IOBUS_OUT  = vecs[i].data;
      IOBUS_WR   = vecs[i].wr;
      #1;
      check({vecs[i].name, " rd"}, IOBUS_IN, vecs[i].exp_rd);
      check({vecs[i].name, " intr"}, {31'd0, INTR}, {31'd0, vecs[i].exp_intr});
      @(negedge CLK);
    end
    IOBUS_WR = 1'b0;

    // asynchronous reset mid-count with INTR high
    bus_write(B + 32'h4, 32'h0);
    bus_write(B + 32'h0, 32'h7);
    idle(1);
    rd("rst pre status", B + 32'hC, 32'h1);
    chk_intr("rst pre intr", 1'b1);
    bus_write(B + 32'h4, 32'h5);
    rd("rst pre count", B + 32'h8, 32'h5);
    #2;
    RST_N = 1'b0;
    #1;
    chk_intr("rst intr async", 1'b0);
    rd("rst count async", B + 32'h8, 32'h0);
    rd("rst ctrl async", B + 32'h0, 32'h0);
    rd("rst load async", B + 32'h4, 32'h0);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);

    // STATUS write-1-clear on the expiry edge
    bus_write(B + 32'h4, 32'h2);
    bus_write(B + 32'h0, 32'h7);
    idle(2);
    rd("w1c align count", B + 32'h8, 32'h0);
    bus_write(B + 32'hC, 32'h1);
    rd("w1c race status", B + 32'hC, 32'h1);
    chk_intr("w1c race intr", 1'b1);
    bus_write(B + 32'hC, 32'h1);
    rd("w1c clear status", B + 32'hC, 32'h0);
    chk_intr("w1c clear intr", 1'b0);
    bus_write(B + 32'h0, 32'h0);

    // LOAD write on tick edges
    bus_write(B + 32'h4, 32'h20);
    bus_write(B + 32'h0, 32'h1);
    idle(1);
    rd("coll align count", B + 32'h8, 32'h1F);
    bus_write(B + 32'h4, 32'h10);
    rd("coll load 10", B + 32'h8, 32'h10);
    bus_write(B + 32'h4, 32'h1);
    idle(1);
    rd("coll zero count", B + 32'h8, 32'h0);
    bus_write(B + 32'h4, 32'h5);
    rd("coll no expiry", B + 32'hC, 32'h0);
    rd("coll count 5", B + 32'h8, 32'h5);
    rd("coll ctrl en", B + 32'h0, 32'h1);

    // CTRL write on the hardware EN-clear edge
    bus_write(B + 32'h4, 32'h0);
    bus_write(B + 32'h0, 32'h1);
    rd("swen ctrl kept", B + 32'h0, 32'h1);
    rd("swen status", B + 32'hC, 32'h1);
    rd("swen count", B + 32'h8, 32'h0);
    idle(1);
    rd("swen hw clear", B + 32'h0, 32'h0);
    bus_write(B + 32'hC, 32'h1);
    rd("swen status clr", B + 32'hC, 32'h0);

    // auto-reload, prescale 1 when the prescaler exists, IE=0
    bus_write(B + 32'h4, 32'h2);
    bus_write(B + 32'h0, 32'h0103);
    rd("ar ctrl", B + 32'h0, CTRL_103_RD);
    for (int k = 0; k < 13; k++) begin
      rd($sformatf("ar count k%0d", k), B + 32'h8, exp_cnt[k]);
      rd($sformatf("ar status k%0d", k), B + 32'hC, exp_st[k]);
      chk_intr($sformatf("ar intr k%0d", k), 1'b0);
      idle(1);
    end
    bus_write(B + 32'h0, 32'h0);

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
